// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and read-mode type for the synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_DEF_DATA_WIDTH    = 8;
    localparam int c_DEF_ADDR_WIDTH    = 6;
    localparam int c_DEF_AFULL_THRESH  = 56;
    localparam int c_DEF_AEMPTY_THRESH = 8;

    typedef enum logic [0:0] {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? MODE_FWFT : MODE_STD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x DATA_WIDTH storage, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately not reset; validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync_param.sv
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO, standard or FWFT read mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = c_DEF_ADDR_WIDTH,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = c_DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = c_DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam fifo_mode_e         c_MODE     = mode_of(FWFT);
    localparam logic [ADDR_WIDTH:0] c_FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_AFULL    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // All flags derive from the registered count, never from the requests.
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    assign full      = w_full;
    assign empty     = w_empty;
    assign afull     = (r_count >= c_AFULL);
    assign aempty    = (r_count <= c_AEMPTY);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clearing wins over a same-cycle offending request.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .wr_en (w_wr_acc),
        .waddr (r_wptr[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (r_rptr[ADDR_WIDTH-1:0]),
        .rdata (w_mem_rdata)
    );

    generate
        if (c_MODE == MODE_FWFT) begin : g_fwft
            assign rdata    = w_mem_rdata;
            assign rd_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata    <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_mem_rdata;
                    end
                end
            end

            assign rdata    = r_rdata;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Directed self-checking bench, standard and FWFT instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int c_DW = 8;
    localparam int c_AW = 6;
    localparam fifo_mode_e c_STD_CFG  = MODE_STD;
    localparam fifo_mode_e c_FWFT_CFG = MODE_FWFT;

    logic            clk = 1'b0;
    logic            rst, wr_en, rd_en, clr_err;
    logic [c_DW-1:0] wdata;

    logic [c_DW-1:0] s_rdata, f_rdata;
    logic            s_rd_valid, f_rd_valid;
    logic            s_full, f_full, s_empty, f_empty;
    logic            s_afull, f_afull, s_aempty, f_aempty;
    logic [c_AW:0]   s_count, f_count;
    logic            s_ovf, f_ovf, s_unf, f_unf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(int'(c_STD_CFG)),
        .AFULL_THRESH(56), .AEMPTY_THRESH(8)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(s_rdata), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .afull(s_afull), .aempty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    fifo_sync_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(int'(c_FWFT_CFG)),
        .AFULL_THRESH(56), .AEMPTY_THRESH(8)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(f_rdata), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .afull(f_afull), .aempty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_count",    int'(s_count), 0);
        chk("rst_empty",    int'(s_empty), 1);
        chk("rst_aempty",   int'(s_aempty), 1);
        chk("rst_full",     int'(s_full), 0);
        chk("rst_afull",    int'(s_afull), 0);
        chk("rst_ovf",      int'(s_ovf), 0);
        chk("rst_unf",      int'(s_unf), 0);
        chk("rst_rd_valid", int'(s_rd_valid), 0);
        chk("rst_rdata",    int'(s_rdata), 0);
        chk("rst_fwft_val", int'(f_rd_valid), 0);

        // Fill 0..63, flags tracked at every occupancy level.
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wdata = c_DW'(i);
            tick();
            chk("fill_count",  int'(s_count), i + 1);
            chk("fill_afull",  int'(s_afull), (i + 1 >= 56) ? 1 : 0);
            chk("fill_aempty", int'(s_aempty), (i + 1 <= 8) ? 1 : 0);
            chk("fill_full",   int'(s_full), (i == 63) ? 1 : 0);
        end
        chk("fill_ovf_pre", int'(s_ovf), 0);
        wdata = 8'd99;
        tick();
        wr_en = 1'b0;
        chk("ovf_count", int'(s_count), 64);
        chk("ovf_flag",  int'(s_ovf), 1);
        chk("fwft_head_at_full", int'(f_rdata), 0);

        // Drain in standard mode.
        for (int i = 0; i < 64; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_rdata", int'(s_rdata), i);
            chk("drain_valid", int'(s_rd_valid), 1);
        end
        chk("drain_empty", int'(s_empty), 1);
        chk("drain_count", int'(s_count), 0);
        chk("ovf_sticky",  int'(s_ovf), 1);
        tick();
        rd_en = 1'b0;
        chk("unf_flag",  int'(s_unf), 1);
        chk("unf_valid", int'(s_rd_valid), 0);
        chk("unf_hold",  int'(s_rdata), 63);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_ovf", int'(s_ovf), 0);
        chk("clr_unf", int'(s_unf), 0);

        // FWFT: a single write appears without rd_en.
        wr_en = 1'b1; wdata = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("fwft_empty", int'(f_empty), 0);
        chk("fwft_rdata", int'(f_rdata), 8'hA5);
        chk("fwft_valid", int'(f_rd_valid), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", int'(f_empty), 1);
        chk("fwft_pop_valid", int'(f_rd_valid), 0);
        chk("std_a5_rdata",   int'(s_rdata), 8'hA5);

        // Occupancy 32 then sustained simultaneous traffic across wrap.
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wdata = c_DW'(i);
            tick();
        end
        chk("half_count", int'(s_count), 32);
        for (int k = 0; k < 100; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wdata = c_DW'(32 + k);
            tick();
            chk("stream_rdata", int'(s_rdata), k);
            chk("stream_count", int'(s_count), 32);
            chk("stream_fwft",  int'(f_rdata), k + 1);
        end
        rd_en = 1'b0;

        // Queue now holds 100..131; top it up with 200..231.
        for (int j = 0; j < 32; j++) begin
            wr_en = 1'b1; wdata = c_DW'(200 + j);
            tick();
        end
        chk("refull_full", int'(s_full), 1);
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
        tick();
        rd_en = 1'b0;
        chk("fullrw_count", int'(s_count), 63);
        chk("fullrw_ovf",   int'(s_ovf), 1);
        chk("fullrw_rdata", int'(s_rdata), 100);
        wdata = 8'h77;
        tick();
        chk("refill_count", int'(s_count), 64);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; wr_en = 1'b0;
        chk("clr_prio_ovf",   int'(s_ovf), 0);
        chk("clr_prio_count", int'(s_count), 64);

        // Drain to 20, then reset mid-burst.
        for (int j = 0; j < 44; j++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("mid_count", int'(s_count), 20);
        chk("mid_rdata", int'(s_rdata), 212);
        wr_en = 1'b1; wdata = 8'h55; rd_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("mrst_count", int'(s_count), 0);
        chk("mrst_empty", int'(s_empty), 1);
        chk("mrst_ovf",   int'(s_ovf), 0);
        chk("mrst_unf",   int'(s_unf), 0);
        chk("mrst_valid", int'(s_rd_valid), 0);
        chk("mrst_rdata", int'(s_rdata), 0);
        wr_en = 1'b1; wdata = 8'h3C;
        tick();
        wr_en = 1'b0;
        chk("post_fwft_rdata", int'(f_rdata), 8'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rdata", int'(s_rdata), 8'h3C);
        chk("post_valid", int'(s_rd_valid), 1);
        chk("post_count", int'(s_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO: the next generation of the team's FIFO block, generalised in data width and depth, with a selectable read mode (standard or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It sits between same-clock producer and consumer logic and is the synchronous counterpart the class-based testbench drives with the same transaction/scoreboard flow.

## Interface

- DATA_WIDTH, 8, width of wdata/rdata
- ADDR_WIDTH, 6, depth = 2**ADDR_WIDTH (64)
- FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
- AFULL_THRESH, 56, afull asserted when count >= value; legal 1..DEPTH
- AEMPTY_THRESH, 8, aempty asserted when count <= value; legal 0..DEPTH-1

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request (pop in FWFT mode)
- rdata  out  DATA_WIDTH  read data
- rd_valid  out  1  rdata valid (standard mode); equals !empty in FWFT mode
- full, empty  out  1  occupancy flags
- afull, aempty  out  1  threshold flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags
- clr_err  in  1  clears overflow/underflow

## Operation

- Reset (rst=1 at edge): pointers, count = 0; empty=1, aempty=1, full=0, afull=0 (unless AFULL_THRESH … n/a, legal range excludes 0); overflow=underflow=0; rd_valid=0; rdata=0 in standard mode. Memory contents not cleared. Reset mid-operation discards all data.
- Pointers ADDR_WIDTH+1 bits; low bits index memory, wrap modulo 2*DEPTH naturally.
- Write accepted iff wr_en & !full. Read accepted iff rd_en & !empty. Flags evaluated from registered count at start of cycle.
- wr_en & full: write dropped, overflow set. rd_en & empty: no pop, underflow set. Sticky until clr_err or rst; clr_err has priority over a same-cycle set.
- Simultaneous accepted write and read: count unchanged, both pointers advance. When full, simultaneous wr/rd: read accepted, write dropped + overflow (full decides).
- count next = count + wr_acc - rd_acc. full = count==DEPTH; empty = count==0; afull/aempty compare count to thresholds; all combinational from count register.
- Standard mode: rdata registered from mem[rptr] on accepted read; holds last value otherwise.
- FWFT mode: rdata = mem[rptr] combinational; valid whenever !empty; rd_en pops.

## Timing

- Write latency: wdata at edge N; count/empty/afull reflect it after edge N (visible cycle N+1).
- Standard read: rd_en accepted at edge N → rdata, rd_valid=1 during cycle N+1; rd_valid=0 cycle after non-accepted read.
- FWFT: word written at edge N appears on rdata, empty=0 in cycle N+1.
- Back-to-back reads/writes every cycle sustained, full throughput.
- Error flags set the cycle after the offending request.

## Structure

- fifo_pkg gains defaults DATA_WIDTH, ADDR_WIDTH, AFULL/AEMPTY defaults and typedef enum {MODE_STD, MODE_FWFT} fifo_mode_e used by bench config.
- Sub-module fifo_mem: DEPTH×DATA_WIDTH array, synchronous write port, asynchronous read port; control/pointers/flags in the top.

## Test plan

- Reset then fill 64 writes (data 0..63) → full=1 at cycle after 64th, afull=1 from count 56, count=64; 65th write → overflow=1, count stays 64.
- Drain 64 reads (standard) → rdata 0..63 in order one cycle after each rd_en; empty=1 after last; extra read → underflow=1, rd_valid=0.
- FWFT: write 0xA5 into empty FIFO → rdata=0xA5, empty=0 next cycle without rd_en; rd_en → empty=1.
- Count 32, simultaneous wr/rd for 100 cycles → count stays 32, data order preserved across pointer wrap.
- Full + simultaneous wr/rd → count 63, overflow=1; clr_err with wr_en on full same cycle → overflow=0.
- rst asserted at count 20 mid-burst → next cycle count=0, empty=1, errors 0, subsequent write/read returns new data only.
